obstacle_spawner: RTL and testbench

Produces the scrolling obstacle field consumed by the game-logic collision checker. It runs on the 60 Hz frame clock and keeps up to OBST_COUNT rectangular obstacles. New obstacles spawn at the right screen edge at a fixed frame period, with top/bottom anchoring and height chosen by an LFSR. Each frame, obstacles scroll left and are retired once they leave the screen. Behaviour follows the shared `gamemode` bus: clear in 00, run in 01, hold in 10 and 11.

---
 rtl/obstacle_spawner.sv | 158 +++++++++++++++
 tb/tb_obstacle_spawner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: scrolling obstacle field for the collision checker; define OBST_SPEEDUP_EN for spawn-driven speed-up
module obstacle_spawner #(
   parameter int          OBST_COUNT     = 10,
   parameter int          SCREEN_W       = 640,
   parameter int          OBST_W         = 40,
   parameter int          UPPER_BOUND    = 20,
   parameter int          LOWER_BOUND    = 460,
   parameter int          MIN_H          = 80,
   parameter int          SPAWN_PERIOD   = 30,
   parameter int          BASE_SPEED     = 4,
`ifdef OBST_SPEEDUP_EN
   parameter int          MAX_SPEED      = 10,
   parameter int          SPEEDUP_SPAWNS = 8,
`endif
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  gamemode,
   output logic [9:0]  obstacle_x_left  [OBST_COUNT],
   output logic [9:0]  obstacle_x_right [OBST_COUNT],
   output logic [8:0]  obstacle_y_up    [OBST_COUNT],
   output logic [8:0]  obstacle_y_down  [OBST_COUNT],
   output logic [15:0] score
);
   localparam logic [15:0] TIMER_LAST = 16'(SPAWN_PERIOD - 1);
   localparam logic [9:0]  BASE_SPD   = 10'(BASE_SPEED);

   logic [OBST_COUNT-1:0] active_q, active_d;
   logic [9:0]  xl_q [OBST_COUNT];
   logic [9:0]  xl_d [OBST_COUNT];
   logic [9:0]  xr_q [OBST_COUNT];
   logic [9:0]  xr_d [OBST_COUNT];
   logic [8:0]  yu_q [OBST_COUNT];
   logic [8:0]  yu_d [OBST_COUNT];
   logic [8:0]  yd_q [OBST_COUNT];
   logic [8:0]  yd_d [OBST_COUNT];
   logic [15:0] timer_q, timer_d, lfsr_q, lfsr_d, score_q, score_d;
   logic [9:0]  speed_q, speed_d;
   logic [8:0]  h, spawn_yu, spawn_yd;
   logic [16:0] score_sum;
   logic [15:0] retired;
   logic        spawn_due, spawned;
`ifdef OBST_SPEEDUP_EN
   logic [15:0] spawn_cnt_q, spawn_cnt_d;
`endif

   assign h         = 9'(MIN_H) + {2'b00, lfsr_q[6:0]};
   assign spawn_yu  = lfsr_q[15] ? 9'(LOWER_BOUND) - h : 9'(UPPER_BOUND);
   assign spawn_yd  = lfsr_q[15] ? 9'(LOWER_BOUND) : 9'(UPPER_BOUND) + h;
   assign spawn_due = timer_q == TIMER_LAST;

   assign obstacle_x_left  = xl_q;
   assign obstacle_x_right = xr_q;
   assign obstacle_y_up    = yu_q;
   assign obstacle_y_down  = yd_q;
   assign score            = score_q;

   // next frame: clear wipes everything, run retires/scrolls/spawns, pause and crash hold
   always_comb begin
      active_d  = active_q;
      xl_d      = xl_q;
      xr_d      = xr_q;
      yu_d      = yu_q;
      yd_d      = yd_q;
      timer_d   = timer_q;
      lfsr_d    = lfsr_q;
      score_d   = score_q;
      speed_d   = speed_q;
      score_sum = '0;
      retired   = '0;
      spawned   = 1'b0;
`ifdef OBST_SPEEDUP_EN
      spawn_cnt_d = spawn_cnt_q;
`endif
      if (gamemode == 2'b00) begin
         active_d = '0;
         for (int i = 0; i < OBST_COUNT; i++) begin
            xl_d[i] = '0;
            xr_d[i] = '0;
            yu_d[i] = '0;
            yd_d[i] = '0;
         end
         timer_d = '0;
         lfsr_d  = LFSR_SEED;
         speed_d = BASE_SPD;
         score_d = '0;
`ifdef OBST_SPEEDUP_EN
         spawn_cnt_d = '0;
`endif
      end else if (gamemode == 2'b01) begin
         for (int i = 0; i < OBST_COUNT; i++) begin
            if (active_q[i] && xr_q[i] <= speed_q) begin
               active_d[i] = 1'b0;
               xl_d[i]     = '0;
               xr_d[i]     = '0;
               yu_d[i]     = '0;
               yd_d[i]     = '0;
               retired     = retired + 16'd1;
            end else if (active_q[i]) begin
               xr_d[i] = xr_q[i] - speed_q;
               xl_d[i] = xl_q[i] < speed_q ? 10'd0 : xl_q[i] - speed_q;
            end else if (spawn_due && !spawned) begin
               spawned     = 1'b1;
               active_d[i] = 1'b1;
               xl_d[i]     = 10'(SCREEN_W);
               xr_d[i]     = 10'(SCREEN_W + OBST_W);
               yu_d[i]     = spawn_yu;
               yd_d[i]     = spawn_yd;
            end
         end
         score_sum = {1'b0, score_q} + {1'b0, retired};
         score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
         timer_d   = spawn_due ? 16'd0 : timer_q + 16'd1;
`ifdef OBST_SPEEDUP_EN
         if (spawned) begin
            spawn_cnt_d = spawn_cnt_q == 16'(SPEEDUP_SPAWNS - 1) ? 16'd0 : spawn_cnt_q + 16'd1;
            if (spawn_cnt_q == 16'(SPEEDUP_SPAWNS - 1))
               speed_d = speed_q < 10'(MAX_SPEED) ? speed_q + 10'd1 : speed_q;
         end
`endif
      end
   end

   // frame state registers; reset zeroes the field and reloads the LFSR seed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= '0;
         for (int i = 0; i < OBST_COUNT; i++) begin
            xl_q[i] <= '0;
            xr_q[i] <= '0;
            yu_q[i] <= '0;
            yd_q[i] <= '0;
         end
         timer_q <= '0;
         lfsr_q  <= LFSR_SEED;
         speed_q <= BASE_SPD;
         score_q <= '0;
`ifdef OBST_SPEEDUP_EN
         spawn_cnt_q <= '0;
`endif
      end else begin
         active_q <= active_d;
         xl_q     <= xl_d;
         xr_q     <= xr_d;
         yu_q     <= yu_d;
         yd_q     <= yd_d;
         timer_q  <= timer_d;
         lfsr_q   <= lfsr_d;
         speed_q  <= speed_d;
         score_q  <= score_d;
`ifdef OBST_SPEEDUP_EN
         spawn_cnt_q <= spawn_cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed scoreboard bench for obstacle_spawner (default and fast-spawn instances)
module tb_obstacle_spawner;
   localparam int N = 10;

   typedef struct {
      int    due;
      string nm;
      int    kind;
      int    idx;
      int    v0, v1, v2, v3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  gamemode = 2'b01;
   logic [9:0]  xl  [N];
   logic [9:0]  xr  [N];
   logic [8:0]  yu  [N];
   logic [8:0]  yd  [N];
   logic [9:0]  xl2 [N];
   logic [9:0]  xr2 [N];
   logic [8:0]  yu2 [N];
   logic [8:0]  yd2 [N];
   logic [15:0] score, score2;
   exp_t        q[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   obstacle_spawner dut (
      .clk(clk), .rst_n(rst_n), .gamemode(gamemode),
      .obstacle_x_left(xl), .obstacle_x_right(xr),
      .obstacle_y_up(yu), .obstacle_y_down(yd), .score(score)
   );

   obstacle_spawner #(.SPAWN_PERIOD(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .gamemode(gamemode),
      .obstacle_x_left(xl2), .obstacle_x_right(xr2),
      .obstacle_y_up(yu2), .obstacle_y_down(yd2), .score(score2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lfsr_at(int n);
      logic [15:0] v;
      v = 16'hACE1;
      for (int i = 0; i < n; i++) v = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
      return v;
   endfunction

   function automatic int y_up(int n);
      logic [15:0] v;
      int h;
      v = lfsr_at(n);
      h = 80 + int'(v[6:0]);
      return v[15] ? 460 - h : 20;
   endfunction

   function automatic int y_dn(int n);
      logic [15:0] v;
      int h;
      v = lfsr_at(n);
      h = 80 + int'(v[6:0]);
      return v[15] ? 460 : 20 + h;
   endfunction

   // kinds: 0 dut slot, 1 dut score, 2 dut active count, 3 dut2 active count, 4 dut2 slot
   function automatic void chk(string nm, int kind, int idx, int v0, int v1 = 0, int v2 = 0, int v3 = 0);
      exp_t e;
      e = '{cyc, nm, kind, idx, v0, v1, v2, v3};
      q.push_back(e);
   endfunction

   function automatic void slot(string nm, int kind, int idx, int x0, int x1, int n);
      chk(nm, kind, idx, x0, x1, n < 0 ? 0 : y_up(n), n < 0 ? 0 : y_dn(n));
   endfunction

   task automatic adv(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         automatic exp_t e;
         automatic int a0 = 0, a1 = 0, a2 = 0, a3 = 0;
         e = q.pop_front();
         case (e.kind)
            0: begin a0 = xl[e.idx]; a1 = xr[e.idx]; a2 = yu[e.idx]; a3 = yd[e.idx]; end
            4: begin a0 = xl2[e.idx]; a1 = xr2[e.idx]; a2 = yu2[e.idx]; a3 = yd2[e.idx]; end
            1: a0 = score;
            2: for (int i = 0; i < N; i++) a0 += int'(xr[i] != 10'd0);
            default: for (int i = 0; i < N; i++) a0 += int'(xr2[i] != 10'd0);
         endcase
         total++;
         if (a0 != e.v0 || a1 != e.v1 || a2 != e.v2 || a3 != e.v3) begin
            bad++;
            $display("FAIL %s: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                     e.nm, a0, a1, a2, a3, e.v0, e.v1, e.v2, e.v3);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      adv(1);
      slot("reset_slot0", 0, 0, 0, 0, -1);
      chk("reset_score", 1, 0, 0);
      chk("reset_count", 2, 0, 0);
      chk("reset_count2", 3, 0, 0);
      rst_n = 1'b1;
      adv(20);
      chk("r20_count", 2, 0, 0);
      chk("fast_r20_count", 3, 0, 10);
      slot("fast_r20_slot0", 4, 0, 568, 608, 1);
      slot("fast_r20_slot9", 4, 9, 640, 680, 19);
      adv(2);
      chk("fast_r22_count", 3, 0, 10);
      slot("fast_r22_slot0", 4, 0, 560, 600, 1);
      slot("fast_r22_slot9_no_respawn", 4, 9, 632, 672, 19);
      adv(7);
      chk("r29_no_spawn", 2, 0, 0);
      adv(1);
      slot("r30_first_spawn", 0, 0, 640, 680, 29);
      chk("r30_count", 2, 0, 1);
      adv(10);
      slot("r40_scroll", 0, 0, 600, 640, 29);
      chk("r40_score", 1, 0, 0);
      adv(150);
      slot("r190_xleft_clamp", 0, 0, 0, 40, 29);
      adv(9);
      slot("r199_xright4", 0, 0, 0, 4, 29);
      chk("r199_score", 1, 0, 0);
      adv(1);
      slot("r200_retired", 0, 0, 0, 0, -1);
      chk("r200_score", 1, 0, 1);
      chk("r200_count", 2, 0, 5);
      adv(10);
      slot("r210_reuse_slot0", 0, 0, 640, 680, 209);
      chk("r210_count", 2, 0, 6);
      adv(90);
      chk("r300_score", 1, 0, 4);
      chk("r300_count", 2, 0, 6);
      slot("r300_slot3", 0, 3, 640, 680, 299);
      slot("r300_slot0", 0, 0, 280, 320, 209);
      gamemode = 2'b11;
      adv(50);
      chk("crash_score", 1, 0, 4);
      chk("crash_count", 2, 0, 6);
      slot("crash_slot3", 0, 3, 640, 680, 299);
      slot("crash_slot0", 0, 0, 280, 320, 209);
      gamemode = 2'b10;
      adv(50);
      chk("pause_score", 1, 0, 4);
      chk("pause_count", 2, 0, 6);
      slot("pause_slot3", 0, 3, 640, 680, 299);
      slot("pause_slot0", 0, 0, 280, 320, 209);
      gamemode = 2'b01;
      adv(29);
      chk("r329_score", 1, 0, 5);
      chk("r329_count", 2, 0, 5);
      adv(1);
      slot("r330_resume_spawn", 0, 4, 640, 680, 329);
      chk("r330_count", 2, 0, 6);
      gamemode = 2'b00;
      adv(1);
      chk("clear_count", 2, 0, 0);
      chk("clear_score", 1, 0, 0);
      slot("clear_slot4", 0, 4, 0, 0, -1);
      slot("clear_slot0", 0, 0, 0, 0, -1);
      gamemode = 2'b01;
      adv(29);
      chk("clr_r29_count", 2, 0, 0);
      adv(1);
      slot("clr_r30_spawn", 0, 0, 640, 680, 29);
      adv(5);
      rst_n = 1'b0;
      chk("async_count", 2, 0, 0);
      slot("async_slot0", 0, 0, 0, 0, -1);
      adv(2);
      rst_n = 1'b1;
      adv(29);
      chk("rst_r29_count", 2, 0, 0);
      adv(1);
      slot("rst_r30_spawn", 0, 0, 640, 680, 29);
      chk("rst_r30_count", 2, 0, 1);
      @(negedge clk);
      #1;
      total += 4;
      if (xl[0] != 10'd640 || xr[0] != 10'd680) begin
         bad++;
         $display("FAIL final_slot0_x: got %0d/%0d want 640/680", xl[0], xr[0]);
      end
      if (score != 16'd0) begin
         bad++;
         $display("FAIL final_score: got %0d want 0", score);
      end
      if (xl[1] != 10'd0 || xr[1] != 10'd0) begin
         bad++;
         $display("FAIL final_slot1_x: got %0d/%0d want 0/0", xl[1], xr[1]);
      end
      if (yu[1] != 9'd0 || yd[1] != 9'd0) begin
         bad++;
         $display("FAIL final_slot1_y: got %0d/%0d want 0/0", yu[1], yd[1]);
      end
      while (q.size() > 0) begin
         automatic exp_t e;
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL %s: never checked, due=%0d now=%0d", e.nm, e.due, cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
